ov7670_config_sequencer: RTL and testbench

OV7670_CONFIG_SEQUENCER -- requirements
Module: ov7670_config_sequencer

---
 rtl/ov7670_cfg_pkg.sv | 6 +
 rtl/ov7670_reg_rom.sv | 29 ++
 rtl/ov7670_config_sequencer.sv | 92 +++++++++
 tb/tb_ov7670_config_sequencer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/ov7670_cfg_pkg.sv
// ov7670_cfg_pkg: sequencer state encoding and ROM command constants shared by the OV7670 config blocks
package ov7670_cfg_pkg;
  typedef enum logic [3:0] {IDLE, FETCH, DECODE, ISSUE, WAIT_DONE, GAP, DELAY, DONE, ERROR} state_t;
  localparam logic [15:0] END_MARKER = 16'hFFFF;
  localparam logic [7:0] DELAY_CMD = 8'hF0;
endpackage

// File: rtl/ov7670_reg_rom.sv
// ov7670_reg_rom: OV7670 register-write table, one {reg_addr, reg_data} per entry, registered read
module ov7670_reg_rom
  import ov7670_cfg_pkg::*;
#(
  parameter int unsigned ROM_AW = 6
) (
  input  logic              clk,
  input  logic [ROM_AW-1:0] addr,
  output logic [15:0]       data
);
  logic [15:0] entry;
  always_comb begin
    entry = END_MARKER;
    case (int'(addr))
      0: entry = 16'h1280;
      1: entry = 16'hF00A;
      2: entry = 16'h1204;
      3: entry = 16'h1100;
      4: entry = 16'h0C00;
      5: entry = 16'h3E00;
      6: entry = 16'h40D0;
      7: entry = 16'h3A04;
      8: entry = 16'h1418;
      9: entry = 16'h8C00;
      default: entry = END_MARKER;
    endcase
  end
  always_ff @(posedge clk) data <= entry;
endmodule

// File: rtl/ov7670_config_sequencer.sv
// ov7670_config_sequencer: walks the register ROM and issues one SCCB write per entry.
// Define OV7670_CFG_DELAY_CMD_EN to turn F0 entries into millisecond waits instead of writes.
module ov7670_config_sequencer
  import ov7670_cfg_pkg::*;
#(
  parameter int unsigned CLK_FREQ       = 50_000_000,
  parameter logic [7:0]  DEVICE_ADDR    = 8'h42,
  parameter int unsigned GAP_CYCLES     = 1000,
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000,
  parameter int unsigned ROM_AW         = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              cfg_done,
  output logic              cfg_error,
  output logic              sccb_start,
  output logic [7:0]        sccb_dev_addr,
  output logic [7:0]        sccb_reg_addr,
  output logic [7:0]        sccb_reg_data,
  input  logic              sccb_ready,
  input  logic              sccb_done,
  output logic [ROM_AW-1:0] entry_idx
);
  state_t state, state_nx;
  logic [15:0] rom_data;
  logic [31:0] cnt;
  logic accept, advance, is_delay;
  ov7670_reg_rom #(.ROM_AW(ROM_AW)) u_rom (.clk(clk), .addr(entry_idx), .data(rom_data));
`ifdef OV7670_CFG_DELAY_CMD_EN
  localparam int unsigned TICK = CLK_FREQ / 1000;
  logic [31:0] tick_cnt;
  logic [7:0] ms_left;
  assign is_delay = rom_data[15:8] == DELAY_CMD;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
      ms_left <= '0;
    end else if (state == DECODE) begin
      tick_cnt <= '0;
      ms_left <= rom_data[7:0];
    end else if (state == DELAY && ms_left != '0) begin
      if (tick_cnt == TICK - 1) begin
        tick_cnt <= '0;
        ms_left <= ms_left - 8'd1;
      end else tick_cnt <= tick_cnt + 32'd1;
    end
  end
`else
  assign is_delay = 1'b0;
`endif
  always_comb begin
    accept = start && (state == IDLE || state == DONE || state == ERROR);
    advance = 1'b0;
    state_nx = state;
    case (state)
      FETCH:     state_nx = DECODE;
      DECODE:    state_nx = rom_data == END_MARKER ? DONE : is_delay ? DELAY : ISSUE;
      ISSUE:     state_nx = sccb_ready ? WAIT_DONE : ISSUE;
      WAIT_DONE: state_nx = sccb_done ? GAP : cnt == TIMEOUT_CYCLES - 1 ? ERROR : WAIT_DONE;
      GAP:       advance = cnt == GAP_CYCLES - 1;
`ifdef OV7670_CFG_DELAY_CMD_EN
      DELAY:     advance = ms_left == '0;
`endif
      default: ;
    endcase
    if (advance) state_nx = &entry_idx ? DONE : FETCH;
    if (accept) state_nx = FETCH;
  end
  // cnt restarts on every state change, so it measures time spent in the current state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      entry_idx <= '0;
      sccb_reg_addr <= '0;
      sccb_reg_data <= '0;
    end else begin
      state <= state_nx;
      cnt <= state_nx != state ? '0 : cnt + 32'd1;
      if (accept) entry_idx <= '0;
      else if (advance && !(&entry_idx)) entry_idx <= entry_idx + 1'b1;
      if (state == DECODE && rom_data != END_MARKER) {sccb_reg_addr, sccb_reg_data} <= rom_data;
    end
  end
  assign busy = !(state inside {IDLE, DONE, ERROR});
  assign cfg_done = state == DONE;
  assign cfg_error = state == ERROR;
  assign sccb_start = state == ISSUE && sccb_ready;
  assign sccb_dev_addr = DEVICE_ADDR;
endmodule

// File: tb/tb_ov7670_config_sequencer.sv
// tb_ov7670_config_sequencer: table-driven and randomized runs of two sequencers (64- and 4-entry ROM)
// against a ROM-walk model; follows OV7670_CFG_DELAY_CMD_EN when it is defined.
module tb_ov7670_config_sequencer;
  localparam int CLK_FREQ = 100_000, TICK = CLK_FREQ / 1000, GAP = 5, TMO = 50, NT = 11;
`ifdef OV7670_CFG_DELAY_CMD_EN
  localparam bit DLY_EN = 1'b1;
`else
  localparam bit DLY_EN = 1'b0;
`endif
  localparam int N0 = DLY_EN ? 9 : 10, N1 = DLY_EN ? 3 : 4;
  typedef struct packed {int inst; int lat; int hold; bit wh; int n; bit dn;} vec_t;
  logic clk = 1'b0, rst = 1'b1;
  logic start [2], busy [2], cfg_done [2], cfg_error [2], sccb_start [2];
  logic sccb_ready [2] = '{1'b1, 1'b1};
  logic sccb_done [2] = '{1'b0, 1'b0};
  logic [7:0] dev [2], ra [2], rd [2];
  logic [5:0] idx0;
  logic [1:0] idx1;
  logic [15:0] tbl [NT] = '{16'h1280, 16'hF00A, 16'h1204, 16'h1100, 16'h0C00, 16'h3E00,
                            16'h40D0, 16'h3A04, 16'h1418, 16'h8C00, 16'hFFFF};
  logic [15:0] exp_w [$], log_w [$];
  int exp_i [$], exp_dly [$], log_cyc [$], log_idx [$], done_cyc [$];
  int exp_end, end_cyc, cyc = 0, lat = 3, rdy_hold = 0, n_chk = 0, n_err = 0;
  int pend [2] = '{0, 0}, rlow [2] = '{0, 0}, nst [2] = '{0, 0}, nseen [2] = '{0, 0};
  bit withhold = 1'b0;
  bit force_low [2] = '{1'b0, 1'b0}, force_done [2] = '{1'b0, 1'b0};

  ov7670_config_sequencer #(.CLK_FREQ(CLK_FREQ), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO), .ROM_AW(6)) u0 (
    .clk(clk), .rst(rst), .start(start[0]), .busy(busy[0]), .cfg_done(cfg_done[0]), .cfg_error(cfg_error[0]),
    .sccb_start(sccb_start[0]), .sccb_dev_addr(dev[0]), .sccb_reg_addr(ra[0]), .sccb_reg_data(rd[0]),
    .sccb_ready(sccb_ready[0]), .sccb_done(sccb_done[0]), .entry_idx(idx0));
  ov7670_config_sequencer #(.CLK_FREQ(CLK_FREQ), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO), .ROM_AW(2)) u1 (
    .clk(clk), .rst(rst), .start(start[1]), .busy(busy[1]), .cfg_done(cfg_done[1]), .cfg_error(cfg_error[1]),
    .sccb_start(sccb_start[1]), .sccb_dev_addr(dev[1]), .sccb_reg_addr(ra[1]), .sccb_reg_data(rd[1]),
    .sccb_ready(sccb_ready[1]), .sccb_done(sccb_done[1]), .entry_idx(idx1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    for (int i = 0; i < 2; i++)
      if (sccb_start[i]) begin
        nst[i]++;
        log_w.push_back({ra[i], rd[i]});
        log_cyc.push_back(cyc);
        log_idx.push_back(i == 0 ? int'(idx0) : int'(idx1));
      end

  // SCCB master stand-in: answers each write after a random latency, then optionally drops ready
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 2; i++) begin
      sccb_done[i] = force_done[i];
      if (nst[i] != nseen[i]) begin
        nseen[i] = nst[i];
        pend[i] = withhold ? 0 : int'($urandom_range(1, lat));
      end else if (pend[i] > 0) begin
        pend[i]--;
        if (pend[i] == 0) begin
          sccb_done[i] = 1'b1;
          done_cyc.push_back(cyc);
          rlow[i] = rdy_hold;
        end
      end else if (rlow[i] > 0) rlow[i]--;
      sccb_ready[i] = !force_low[i] && rlow[i] == 0;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  // expected writes: walk entries until the end marker or the last address, folding F0 entries into delays
  task automatic build_model(input int depth);
    logic [15:0] e;
    int dly;
    dly = 0;
    exp_w.delete(); exp_i.delete(); exp_dly.delete();
    exp_end = depth - 1;
    for (int i = 0; i < depth; i++) begin
      e = i < NT ? tbl[i] : 16'hFFFF;
      if (e == 16'hFFFF) begin
        exp_end = i;
        break;
      end
      if (DLY_EN && e[15:8] == 8'hF0) dly += int'(e[7:0]);
      else begin
        exp_w.push_back(e);
        exp_i.push_back(i);
        exp_dly.push_back(dly);
        dly = 0;
      end
    end
  endtask

  task automatic clear_log();
    log_w.delete(); log_cyc.delete(); log_idx.delete(); done_cyc.delete();
  endtask

  task automatic wait_end(input int i, input int x);
    end_cyc = -1;
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      if (cfg_done[i] || cfg_error[i]) begin
        end_cyc = cyc;
        break;
      end
      start[i] = c == x;
    end
    start[i] = 1'b0;
    chk("finish_in_budget", int'(end_cyc >= 0), 1);
  endtask

  task automatic run(input int i, input int x);
    clear_log();
    start[i] = 1'b1;
    @(negedge clk);
    start[i] = 1'b0;
    wait_end(i, x);
  endtask

  task automatic check_run(input int i, input int n, input bit dn);
    int idx;
    idx = i == 0 ? int'(idx0) : int'(idx1);
    chk("busy_at_end", int'(busy[i]), 0);
    chk("cfg_done", int'(cfg_done[i]), int'(dn));
    chk("cfg_error", int'(cfg_error[i]), int'(!dn));
    chk("n_writes", log_w.size(), n);
    for (int k = 0; k < log_w.size() && k < exp_w.size(); k++) begin
      chk("write_word", int'(log_w[k]), int'(exp_w[k]));
      chk("write_idx", log_idx[k], exp_i[k]);
      if (k > 0 && exp_dly[k] > 0 && done_cyc.size() >= k)
        chk("delay_gap_ok", int'(log_cyc[k] - done_cyc[k-1] >= exp_dly[k] * TICK), 1);
    end
    if (dn) chk("end_idx", idx, exp_end);
    else if (log_cyc.size() > 0) begin
      chk("timeout_latency", end_cyc - log_cyc[0], TMO + 1);
      chk("err_idx", idx, 0);
    end
  endtask

  initial begin
    vec_t vt [6];
    int sel, x;
    vt = '{'{0, 3, 0, 1'b0, N0, 1'b1}, '{0, 1, 12, 1'b0, N0, 1'b1}, '{1, 7, 0, 1'b0, N1, 1'b1},
           '{0, 4, 0, 1'b1, 1, 1'b0}, '{1, 2, 9, 1'b0, N1, 1'b1}, '{1, 5, 0, 1'b1, 1, 1'b0}};
    start[0] = 1'b0;
    start[1] = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_busy", int'(busy[i]), 0);
      chk("rst_done", int'(cfg_done[i]), 0);
      chk("rst_error", int'(cfg_error[i]), 0);
      chk("rst_sccb_start", int'(sccb_start[i]), 0);
      chk("rst_reg", int'({ra[i], rd[i]}), 0);
      chk("dev_addr", int'(dev[i]), 'h42);
    end
    chk("rst_idx", int'(idx0) + int'(idx1), 0);
    rst = 1'b0;
    @(negedge clk);
    for (int v = 0; v < 6; v++) begin
      build_model(vt[v].inst == 0 ? 64 : 4);
      lat = vt[v].lat;
      rdy_hold = vt[v].hold;
      withhold = vt[v].wh;
      run(vt[v].inst, 100000);
      check_run(vt[v].inst, vt[v].n, vt[v].dn);
      withhold = 1'b0;
    end
    // ready held low while the first write waits in ISSUE
    build_model(64);
    lat = 3;
    rdy_hold = 0;
    force_low[0] = 1'b1;
    @(negedge clk);
    clear_log();
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (100) @(negedge clk);
    chk("no_start_while_not_ready", log_w.size(), 0);
    chk("busy_while_not_ready", int'(busy[0]), 1);
    force_low[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk("one_start_after_ready", log_w.size(), 1);
    wait_end(0, 100000);
    check_run(0, N0, 1'b1);
    // DONE holds through a stray sccb_done
    force_done[0] = 1'b1;
    @(negedge clk);
    force_done[0] = 1'b0;
    repeat (30) @(negedge clk);
    chk("done_holds", int'(cfg_done[0]), 1);
    chk("no_start_in_done", log_w.size(), N0);
    // reset while waiting for sccb_done
    withhold = 1'b1;
    clear_log();
    start[1] = 1'b1;
    @(negedge clk);
    start[1] = 1'b0;
    for (int c = 0; c < 100 && log_w.size() == 0; c++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("in_wait_done", int'(busy[1]) + log_w.size(), 2);
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("async_rst_busy", int'(busy[i]), 0);
      chk("async_rst_flags", int'(cfg_done[i]) + int'(cfg_error[i]) + int'(sccb_start[i]), 0);
      chk("async_rst_reg", int'({ra[i], rd[i]}), 0);
    end
    chk("async_rst_idx", int'(idx0) + int'(idx1), 0);
    @(negedge clk);
    rst = 1'b0;
    withhold = 1'b0;
    force_done[1] = 1'b1;
    @(negedge clk);
    force_done[1] = 1'b0;
    repeat (20) @(negedge clk);
    chk("stray_done_no_start", log_w.size(), 1);
    chk("stray_done_idle", int'(busy[1]) + int'(cfg_done[1]) + int'(cfg_error[1]), 0);
    // randomized latency, ready gaps and ignored mid-run start pulses
    for (int r = 0; r < 6; r++) begin
      sel = int'($urandom_range(0, 1));
      lat = int'($urandom_range(1, 20));
      rdy_hold = int'($urandom_range(0, 15));
      x = int'($urandom_range(0, 200));
      build_model(sel == 0 ? 64 : 4);
      run(sel, x);
      check_run(sel, exp_w.size(), 1'b1);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
